hdr_weight_calc: RTL
====================

# hdr_weight_calc

Parametrised, pipelined pixel-weighting unit for the HDR merge path. It takes one pixel value from each of NUM_EXP exposures per beat and produces a per-exposure weight from a runtime-programmable weighting curve. It also produces the weight sum for the downstream normaliser and flags beats whose weights are all zero. It sits between the exposure alignment buffers and the radiance accumulator, and handles all exposures of a pixel in parallel.

## Interface
- DATA_WIDTH, 8: pixel and weight width in bits.
- NUM_EXP, 3: number of exposures (channels) per beat, ≥1.
- SUM_WIDTH, DATA_WIDTH+$clog2(NUM_EXP+1): width of the weight sum.
- CNT_WIDTH, 16: width of the zero-weight statistics counter.

- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_z holds a valid beat this cycle.
- in_z  in  NUM_EXP*DATA_WIDTH  pixel values; exposure k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- cfg_we  in  1  one-cycle strobe; load cfg_zmin/cfg_zmax/cfg_mode.
- cfg_zmin  in  DATA_WIDTH  lower bound of the valid pixel range.
- cfg_zmax  in  DATA_WIDTH  upper bound of the valid pixel range.
- cfg_mode  in  2  curve: 0 hat, 1 box, 2 hat with floor 1, 3 treated as 0.
- cfg_err  out  1  sticky flag: a rejected config write has occurred.
- cnt_clr  in  1  clears zero_cnt and cfg_err.
- out_valid  out  1  outputs are valid this cycle.
- out_weight  out  NUM_EXP*DATA_WIDTH  weights; same packing as in_z.
- out_wsum  out  SUM_WIDTH  sum of all out_weight lanes.
- out_zero  out  1  out_wsum == 0.
- zero_cnt  out  CNT_WIDTH  saturating count of beats with out_zero set.

## Operation
- **Config registers:** zmin, zmax, mode.
  - Reset values: zmin=0, zmax=2^DATA_WIDTH−1, mode=0.
  - A cfg_we with cfg_zmin < cfg_zmax loads all three on the next edge.
  - A cfg_we with cfg_zmin ≥ cfg_zmax is ignored. Registers are unchanged and cfg_err is set.
- **Config timing:** a beat samples the config registers when it enters stage 1. A beat accepted in the same cycle as cfg_we uses the old values. No in-flight beat changes curve.
- **Derived values:** mid = (zmin+zmax)>>1, computed at DATA_WIDTH+1 bits then truncated. peak = mid − zmin.
- **Per-lane weight w for pixel z:**
  - z < zmin or z > zmax: w=0 in modes 0/1. In mode 2 the floor rule below still applies.
  - Mode 0 hat: z ≤ mid gives w = z−zmin; otherwise w = zmax−z.
  - Mode 1 box: w = peak for all z in [zmin, zmax].
  - Mode 2: hat value, then w = max(w, 1) for every z, including z outside the range. out_zero can therefore never assert in mode 2.
- **Pipeline:** 3 stages, no backpressure, one beat per cycle.
  - S1 registers z, the range compare results and the config snapshot.
  - S2 computes and registers the weights.
  - S3 registers out_weight, the adder-tree sum out_wsum, out_zero, and out_valid.
  - Valid bits shift alongside the data. Data registers may hold stale values when valid is low.
- **zero_cnt:**
  - Increments on each cycle with out_valid && out_zero.
  - Saturates at 2^CNT_WIDTH−1.
  - cnt_clr takes priority over an increment in the same cycle; the result is 0.
  - cnt_clr and a rejected cfg_we in the same cycle leave cfg_err set, because the error write wins.

## Timing
- Latency: in_valid at edge N gives out_valid at edge N+3. Throughput is 1 beat per cycle.
- Reset values of all outputs: out_valid=0, out_weight=0, out_wsum=0, out_zero=0, zero_cnt=0, cfg_err=0.
- reset asserted mid-stream flushes all valid bits. Beats in flight are lost and out_valid is 0 on the cycle after reset. The config registers return to their defaults.
- A config write takes effect for beats accepted from cycle N+1 onward, where cfg_we is sampled at edge N.
- cfg_err is visible one cycle after the bad cfg_we.

## Test plan
- **Default hat curve.** Defaults, DATA_WIDTH=8, NUM_EXP=3, in_z lanes {0,127,128} -> out_weight {0,127,127}, out_wsum=254, out_valid exactly 3 cycles after in_valid.
- **Narrowed range, then box mode.** cfg zmin=16, zmax=240, mode 0; lanes {10,100,200} -> weights {0,84,40}, sum 124. Then mode 1 with the same lanes -> {0,112,112}.
- **All-zero beats and counter saturation.** Lanes {0,255,0} under defaults -> out_zero=1 and zero_cnt increments. Run 70000 such beats at CNT_WIDTH=16 -> zero_cnt holds 65535. cnt_clr -> 0.
- **Mode 2 floor.** Mode 2, lanes {0,255,300 clipped to 8 bits=44} -> weights {1,1,44}, out_zero=0, zero_cnt unchanged.
- **Rejected config.** cfg_we with zmin=200, zmax=100 -> cfg_err=1 on the next cycle and subsequent beats still use the prior curve. cfg_we issued together with in_valid -> that beat uses the old curve and the next beat uses the new one.
- **Reset mid-stream.** Stream continuous beats, then assert reset for 1 cycle with 3 beats in flight -> no out_valid for those beats, all outputs 0, zmax=255 restored.

Source files
------------

// File: rtl/hdr_weight_calc.sv
// hdr_weight_calc: three-stage per-exposure pixel weighting for the HDR merge path.
// Uses a programmable hat, box or floored-hat curve and emits the weight sum, an all-zero flag and a zero-beat counter.
`timescale 1ns/1ps
module hdr_weight_calc #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_EXP    = 3,
  parameter int SUM_WIDTH  = DATA_WIDTH + $clog2(NUM_EXP + 1),
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [NUM_EXP*DATA_WIDTH-1:0] in_z,
  input  logic                          cfg_we,
  input  logic [DATA_WIDTH-1:0]         cfg_zmin,
  input  logic [DATA_WIDTH-1:0]         cfg_zmax,
  input  logic [1:0]                    cfg_mode,
  output logic                          cfg_err,
  input  logic                          cnt_clr,
  output logic                          out_valid,
  output logic [NUM_EXP*DATA_WIDTH-1:0] out_weight,
  output logic [SUM_WIDTH-1:0]          out_wsum,
  output logic                          out_zero,
  output logic [CNT_WIDTH-1:0]          zero_cnt
);

  // in_valid qualifies in_z for exactly the cycle it is high. There is no ready signal, so every
  // valid beat is taken. out_valid marks its result for one cycle, three cycles later.
  // Data registers are don't-care whenever their valid bit is low.

  localparam int DW          = DATA_WIDTH;
  localparam int NE          = NUM_EXP;
  localparam int TREE_LEAVES = 1 << $clog2(NE);
  localparam int TREE_NODES  = 2 * TREE_LEAVES - 1;

  typedef enum logic [1:0] {
    MODE_HAT   = 2'd0,
    MODE_BOX   = 2'd1,
    MODE_FLOOR = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef logic [NE-1:0][DW-1:0] lanes_t;

  // ---------------- configuration registers ----------------
  logic [DW-1:0] zmin_q, zmin_d, zmax_q, zmax_d;
  mode_e         mode_q, mode_d;
  logic          cfg_err_q, cfg_err_d;
  logic          cfg_ok;

  always_comb begin
    zmin_d    = zmin_q;
    zmax_d    = zmax_q;
    mode_d    = mode_q;
    cfg_err_d = cfg_err_q;
    cfg_ok    = (cfg_zmin < cfg_zmax);
    if (cnt_clr) cfg_err_d = 1'b0;
    // A rejected write outranks a same-cycle clear of the error flag.
    if (cfg_we) begin
      if (cfg_ok) begin
        zmin_d = cfg_zmin;
        zmax_d = cfg_zmax;
        mode_d = mode_e'(cfg_mode);
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      zmin_q    <= '0;
      zmax_q    <= '1;
      mode_q    <= MODE_HAT;
      cfg_err_q <= 1'b0;
    end else begin
      zmin_q    <= zmin_d;
      zmax_q    <= zmax_d;
      mode_q    <= mode_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  logic [DW:0]   zpair_sum;
  logic [DW-1:0] mid, peak;

  assign zpair_sum = {1'b0, zmin_q} + {1'b0, zmax_q};
  assign mid       = zpair_sum[DW:1];
  assign peak      = mid - zmin_q;

  // ---------------- stage 1: capture, range compare, config snapshot ----------------
  lanes_t        z_in, z1_q;
  logic [NE-1:0] lo1_d, hi1_d, le1_d;
  logic [NE-1:0] lo1_q, hi1_q, le1_q;
  logic          v1_q;
  logic [DW-1:0] zmin1_q, zmax1_q, peak1_q;
  mode_e         mode1_q;

  assign z_in = in_z;

  always_comb begin
    lo1_d = '0;
    hi1_d = '0;
    le1_d = '0;
    for (int k = 0; k < NE; k++) begin
      lo1_d[k] = (z_in[k] < zmin_q);
      hi1_d[k] = (z_in[k] > zmax_q);
      le1_d[k] = (z_in[k] <= mid);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q    <= 1'b0;
      z1_q    <= '0;
      lo1_q   <= '0;
      hi1_q   <= '0;
      le1_q   <= '0;
      zmin1_q <= '0;
      zmax1_q <= '0;
      peak1_q <= '0;
      mode1_q <= MODE_HAT;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        z1_q    <= z_in;
        lo1_q   <= lo1_d;
        hi1_q   <= hi1_d;
        le1_q   <= le1_d;
        zmin1_q <= zmin_q;
        zmax1_q <= zmax_q;
        peak1_q <= peak;
        mode1_q <= mode_q;
      end
    end
  end

  // ---------------- stage 2: weight curve ----------------
  lanes_t        hat, w2_d, w2_q;
  logic [NE-1:0] in_rng;
  logic          v2_q;

  always_comb begin
    hat    = '0;
    in_rng = '0;
    w2_d   = '0;
    for (int k = 0; k < NE; k++) begin
      in_rng[k] = ~lo1_q[k] & ~hi1_q[k];
      hat[k]    = le1_q[k] ? (z1_q[k] - zmin1_q) : (zmax1_q - z1_q[k]);
      case (mode1_q)
        MODE_BOX:   w2_d[k] = in_rng[k] ? peak1_q : '0;
        // The floor applies even outside the range, so this mode never yields a zero weight.
        MODE_FLOOR: w2_d[k] = (in_rng[k] && (hat[k] != '0)) ? hat[k] : DW'(1);
        default:    w2_d[k] = in_rng[k] ? hat[k] : '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v2_q <= 1'b0;
      w2_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) w2_q <= w2_d;
    end
  end

  // ---------------- stage 3: adder tree and outputs ----------------
  logic [SUM_WIDTH-1:0] node [TREE_NODES];
  logic [SUM_WIDTH-1:0] wsum_d;

  // Heap-ordered binary tree. Leaves sit at TREE_LEAVES-1 and above, and unused leaves stay at zero.
  always_comb begin
    for (int i = 0; i < TREE_NODES; i++) node[i] = '0;
    for (int k = 0; k < NE; k++) node[TREE_LEAVES - 1 + k] = SUM_WIDTH'(w2_q[k]);
    for (int i = TREE_LEAVES - 2; i >= 0; i--) node[i] = node[2*i + 1] + node[2*i + 2];
    wsum_d = node[0];
  end

  lanes_t               out_weight_q;
  logic [SUM_WIDTH-1:0] out_wsum_q;
  logic                 out_zero_q, out_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_weight_q <= '0;
      out_wsum_q   <= '0;
      out_zero_q   <= 1'b0;
    end else begin
      out_valid_q <= v2_q;
      if (v2_q) begin
        out_weight_q <= w2_q;
        out_wsum_q   <= wsum_d;
        out_zero_q   <= (wsum_d == '0);
      end
    end
  end

  // ---------------- zero-weight statistics ----------------
  logic [CNT_WIDTH-1:0] zero_cnt_q, zero_cnt_d;

  always_comb begin
    zero_cnt_d = zero_cnt_q;
    if (cnt_clr) zero_cnt_d = '0;
    else if (out_valid_q && out_zero_q && (zero_cnt_q != '1)) zero_cnt_d = zero_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) zero_cnt_q <= '0;
    else       zero_cnt_q <= zero_cnt_d;
  end

  assign cfg_err    = cfg_err_q;
  assign out_valid  = out_valid_q;
  assign out_weight = out_weight_q;
  assign out_wsum   = out_wsum_q;
  assign out_zero   = out_zero_q;
  assign zero_cnt   = zero_cnt_q;

endmodule
